xor_frame_cksum: RTL

- Streaming XOR checksum engine: the parametrised, sequential successor to the single-bit xor1 gate.
- Accepts frames of WIDTH-bit words over a valid/ready handshake and forwards them downstream through one registered output stage.
- GEN mode: appends the running XOR of the frame as one extra trailing word.
- CHECK mode: verifies that the XOR of the whole frame, including its trailing check word, is zero. Also flags over-length frames.
- Sits between a word source and a word sink on the data path.

---
 rtl/xor_pkg.sv | 14 +
 rtl/xor_out_reg.sv | 37 +++
 rtl/xor_frame_cksum.sv | 124 ++++++++++++
 3 files changed

// File: rtl/xor_pkg.sv
// Shared state and mode definitions for the streaming XOR frame checksum engine.
package xor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STREAM  = 2'd1,
    APPEND  = 2'd2,
    END_CHK = 2'd3
  } state_t;

  localparam logic MODE_GEN   = 1'b0;
  localparam logic MODE_CHECK = 1'b1;

endpackage

// File: rtl/xor_out_reg.sv
// Single-entry output register with valid/ready hold; accepts a new word
// whenever empty or when the held word is leaving in the same cycle.
module xor_out_reg #(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          vld_p0;
  logic [DW-1:0] data_p0;

  assign in_ready = !vld_p0 || out_ready;

  // Stage p0: the only register between the input and the sink.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else if (in_valid && in_ready) begin
      vld_p0  <= 1'b1;
      data_p0 <= in_data;
    end else if (out_ready) begin
      vld_p0  <= 1'b0;
    end
  end

  assign out_valid = vld_p0;
  assign out_data  = data_p0;

endmodule

// File: rtl/xor_frame_cksum.sv
// Streaming XOR checksum engine: GEN appends the frame XOR as a trailing word,
// CHECK verifies the frame (check word included) XORs to zero.
module xor_frame_cksum
  import xor_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] frame_len
);

  state_t           state;
  logic             frame_mode;
  logic [WIDTH-1:0] acc;
  logic [LEN_W-1:0] count;
  logic             ovf;
  logic             cks_loaded;
  logic             out_ready;
  logic             load_vld;
  logic [WIDTH:0]   load_word;
  logic [WIDTH:0]   out_word;
  logic             in_fire;
  logic             m_fire;
  logic             start;
  logic             cur_mode;

  assign s_ready  = (state != APPEND) && out_ready;
  assign in_fire  = s_valid && s_ready;
  assign m_fire   = m_valid && m_ready;
  // END_CHK can open the next frame on the same cycle its last word leaves.
  assign start    = in_fire && (state == IDLE || state == END_CHK);
  assign cur_mode = start ? mode : frame_mode;

  always_comb begin
    load_vld  = in_fire;
    load_word = {(cur_mode == MODE_CHECK) && s_last, s_data};
    if (state == APPEND && !cks_loaded) begin
      load_vld  = out_ready;
      load_word = {1'b1, acc};
    end
  end

  xor_out_reg #(
    .DW(WIDTH + 1)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (load_vld),
    .in_ready (out_ready),
    .in_data  (load_word),
    .out_valid(m_valid),
    .out_ready(m_ready),
    .out_data (out_word)
  );

  assign m_last = out_word[WIDTH];
  assign m_data = out_word[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      frame_mode <= MODE_GEN;
      acc        <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      cks_loaded <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      frame_len  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      if (state == END_CHK && m_fire) begin
        done      <= 1'b1;
        err       <= ovf || (acc != '0);
        frame_len <= count;
        state     <= IDLE;
      end

      // APPEND waits for the register to free, then for the checksum to leave.
      if (state == APPEND) begin
        if (!cks_loaded) begin
          cks_loaded <= out_ready;
        end else if (m_fire) begin
          done       <= 1'b1;
          err        <= ovf;
          frame_len  <= count;
          cks_loaded <= 1'b0;
          state      <= IDLE;
        end
      end

      if (start) begin
        frame_mode <= mode;
        acc        <= s_data;
        count      <= LEN_W'(1);
        ovf        <= 1'b0;
        if (s_last) state <= (mode == MODE_GEN) ? APPEND : END_CHK;
        else        state <= STREAM;
      end else if (state == STREAM && in_fire) begin
        acc <= acc ^ s_data;
        if (count == LEN_W'(MAX_LEN)) ovf   <= 1'b1;
        else                          count <= count + LEN_W'(1);
        if (s_last) state <= (frame_mode == MODE_GEN) ? APPEND : END_CHK;
      end
    end
  end

endmodule
